// File: rtl/tsn_policer_pkg.sv
// Shared definitions for the TSN credit-based policer: FSM encoding, credit widths
// and the saturating clamp that keeps the 32-bit credit from ever wrapping.
package tsn_policer_pkg;

  localparam int CREDIT_W = 32;
  localparam int ACC_W    = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } frame_state_e;

  // Wide intermediate result is pinned into [lo, hi] before narrowing to CREDIT_W.
  function automatic logic signed [CREDIT_W-1:0] sat_clamp(
    input logic signed [ACC_W-1:0]    value,
    input logic signed [CREDIT_W-1:0] lo,
    input logic signed [CREDIT_W-1:0] hi
  );
    logic signed [ACC_W-1:0] lo_ext;
    logic signed [ACC_W-1:0] hi_ext;
    lo_ext = {{(ACC_W-CREDIT_W){lo[CREDIT_W-1]}}, lo};
    hi_ext = {{(ACC_W-CREDIT_W){hi[CREDIT_W-1]}}, hi};
    if (value > hi_ext) begin
      return hi;
    end else if (value < lo_ext) begin
      return lo;
    end else begin
      return value[CREDIT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/credit_based_policer_if.sv
// AXI4-Stream bundle used on both sides of the policer.
interface credit_based_policer_if #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH/8
);

  logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
  logic [C_AXIS_TKEEP_WIDTH-1:0] tkeep;
  logic                          tvalid;
  logic                          tready;
  logic                          tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/tkeep_popcount.sv
// Combinational count of asserted byte enables in one stream beat.
module tkeep_popcount #(
  parameter int C_AXIS_TKEEP_WIDTH = 1
) (
  input  logic [C_AXIS_TKEEP_WIDTH-1:0]         i_tkeep,
  output logic [$clog2(C_AXIS_TKEEP_WIDTH+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(C_AXIS_TKEEP_WIDTH+1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
      o_count = o_count + CNT_W'(i_tkeep[i]);
    end
  end

endmodule

// File: rtl/credit_based_policer.sv
// Ingress credit-based policer: admits or drops whole AXI4-Stream frames on the first beat.
// Optional frame counters are built only when CREDIT_BASED_POLICER_STATS_EN is defined.
module credit_based_policer
  import tsn_policer_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH/8,
  parameter int L1_LENGTH_OFFSET   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_policer_enable,
  input  logic signed [CREDIT_W-1:0] i_idle_slope,
  input  logic signed [CREDIT_W-1:0] i_byte_cost,
  input  logic signed [CREDIT_W-1:0] i_max_credit,
  input  logic signed [CREDIT_W-1:0] i_min_credit,
  output logic signed [CREDIT_W-1:0] o_credit,
  output logic [1:0]                 o_frame_state,
  output logic [31:0]                o_passed_frames,
  output logic [31:0]                o_dropped_frames,
  credit_based_policer_if.slave      s_axis,
  credit_based_policer_if.master     m_axis
);

  localparam int CNT_W = $clog2(C_AXIS_TKEEP_WIDTH+1);

  frame_state_e              r_state;
  frame_state_e              w_next_state;
  logic signed [CREDIT_W-1:0] r_credit;
  logic signed [CREDIT_W-1:0] w_next_credit;

  logic                    w_admit;
  logic                    w_fwd;
  logic                    w_fwd_hs;
  logic                    w_drop_beat;
  logic                    w_frame_passed;
  logic                    w_frame_dropped;
  logic [CNT_W-1:0]        w_keep_cnt;
  logic signed [ACC_W-1:0] w_beat_bytes;
  logic signed [ACC_W-1:0] w_charge;
  logic signed [ACC_W-1:0] w_credit_ext;
  logic signed [ACC_W-1:0] w_slope_ext;
  logic signed [ACC_W-1:0] w_cost_ext;
  logic signed [ACC_W-1:0] w_sum;

  tkeep_popcount #(
    .C_AXIS_TKEEP_WIDTH(C_AXIS_TKEEP_WIDTH)
  ) u_tkeep_popcount (
    .i_tkeep (s_axis.tkeep),
    .o_count (w_keep_cnt)
  );

  // The decision only matters in IDLE; once in PASS/DROP it is latched by the state itself.
  assign w_admit = !i_policer_enable || (r_credit >= 0);
  assign w_fwd   = (r_state == ST_PASS) || ((r_state == ST_IDLE) && w_admit);

  assign m_axis.tvalid = w_fwd ? s_axis.tvalid : 1'b0;
  assign s_axis.tready = w_fwd ? m_axis.tready : 1'b1;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;

  assign w_fwd_hs        = w_fwd && s_axis.tvalid && m_axis.tready;
  assign w_drop_beat     = !w_fwd && s_axis.tvalid;
  assign w_frame_passed  = w_fwd_hs && s_axis.tlast;
  assign w_frame_dropped = w_drop_beat && s_axis.tlast;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fwd_hs && !s_axis.tlast) begin
          w_next_state = ST_PASS;
        end else if (w_drop_beat && !s_axis.tlast) begin
          w_next_state = ST_DROP;
        end
      end
      ST_PASS: if (w_frame_passed)  w_next_state = ST_IDLE;
      ST_DROP: if (w_frame_dropped) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_credit_ext = {{(ACC_W-CREDIT_W){r_credit[CREDIT_W-1]}}, r_credit};
  assign w_slope_ext  = {{(ACC_W-CREDIT_W){i_idle_slope[CREDIT_W-1]}}, i_idle_slope};
  assign w_cost_ext   = {{(ACC_W-CREDIT_W){i_byte_cost[CREDIT_W-1]}}, i_byte_cost};
  assign w_beat_bytes = w_fwd_hs
                      ? ({{(ACC_W-CNT_W){1'b0}}, w_keep_cnt}
                         + (s_axis.tlast ? ACC_W'(L1_LENGTH_OFFSET) : {ACC_W{1'b0}}))
                      : {ACC_W{1'b0}};
  assign w_charge     = w_cost_ext * w_beat_bytes;
  assign w_sum        = w_credit_ext + w_slope_ext - w_charge;

  // An idle, empty queue may not bank positive credit; debt still recovers at idle_slope.
  always_comb begin
    w_next_credit = sat_clamp(w_sum, i_min_credit, i_max_credit);
    if (!i_policer_enable) begin
      w_next_credit = i_max_credit;
    end else if ((r_state == ST_IDLE) && !s_axis.tvalid && (r_credit > 0)) begin
      w_next_credit = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
    end else begin
      r_state  <= w_next_state;
      r_credit <= w_next_credit;
    end
  end

  assign o_credit      = r_credit;
  assign o_frame_state = r_state;

`ifdef CREDIT_BASED_POLICER_STATS_EN
  logic [31:0] r_passed_frames;
  logic [31:0] r_dropped_frames;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_passed_frames  <= '0;
      r_dropped_frames <= '0;
    end else begin
      if (w_frame_passed && (r_passed_frames != 32'hFFFF_FFFF)) begin
        r_passed_frames <= r_passed_frames + 32'd1;
      end
      if (w_frame_dropped && (r_dropped_frames != 32'hFFFF_FFFF)) begin
        r_dropped_frames <= r_dropped_frames + 32'd1;
      end
    end
  end

  assign o_passed_frames  = r_passed_frames;
  assign o_dropped_frames = r_dropped_frames;
`else
  assign o_passed_frames  = 32'd0;
  assign o_dropped_frames = 32'd0;
`endif

endmodule
